cc_addr_decode_pipe: RTL and testbench
======================================

# cc_addr_decode_pipe

Parametrised, pipelined successor to the cache-controller read-address decoder. It accepts AXI read-address requests from the interconnect and splits each address into tag/index/offset. It registers the decoded request into a two-entry skid buffer that feeds the tag-lookup stage under a valid/ready handshake. It also bounds the number of in-flight reads with an outstanding-request counter, and gates acceptance on any number of downstream almost-full flags.

## Interface
Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- ADDR_W, 32, request address width
- OFFSET_W, 6, line-offset bits (64 B line)
- INDEX_W, 9, set-index bits
- TAG_W, ADDR_W-INDEX_W-OFFSET_W, derived tag width; must not be overridden
- ID_W, 4, AXI ID width
- NUM_AFULL, 4, number of downstream almost-full inputs
- MAX_OUTST, 8, maximum accepted-but-not-retired requests (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inct_araddr_i  in  ADDR_W  request address
- inct_arid_i  in  ID_W  request ID
- inct_arvalid_i  in  1  request valid
- inct_arready_o  out  1  request ready
- afull_i  in  NUM_AFULL  downstream FIFO almost-full flags
- lkup_valid_o  out  1  decoded request valid
- lkup_ready_i  in  1  lookup stage ready
- lkup_tag_o  out  TAG_W  address[ADDR_W-1 : INDEX_W+OFFSET_W]
- lkup_index_o  out  INDEX_W  address[INDEX_W+OFFSET_W-1 : OFFSET_W]
- lkup_offset_o  out  OFFSET_W  address[OFFSET_W-1 : 0]
- lkup_id_o  out  ID_W  request ID
- done_i  in  1  one-cycle pulse: one request retired (read data last beat sent)
- hs_pulse_o  out  1  inct_arvalid_i & inct_arready_o
- outst_cnt_o  out  $clog2(MAX_OUTST+1)  current outstanding count
- err_o  out  1  sticky: done_i seen with count zero

## Operation
- Acceptance: inct_arready_o = !skid_valid & !(|afull_i) & (outst_cnt < MAX_OUTST). This is combinational from registers and afull_i. It has no dependency on inct_arvalid_i.
- Handshake: an input handshake (hs_pulse_o=1) captures {tag, index, offset, id}.
  - If the output register is empty, or is being drained this cycle (lkup_valid_o & lkup_ready_i), the capture goes to the output register.
  - Otherwise the capture goes to the skid register and skid_valid is set.
- Drain: on an output handshake, the output register reloads from the skid register if skid_valid. Otherwise it reloads from a simultaneous input capture, or else goes empty (lkup_valid_o drops).
- Ordering: requests leave strictly in acceptance order. Output fields are stable while lkup_valid_o & !lkup_ready_i.
- Outstanding counter:
  - Increments on hs_pulse_o and decrements on done_i.
  - Both in the same cycle leave it unchanged.
  - done_i at count 0 leaves the count at 0 and sets err_o. err_o clears only on rst.
  - The count never exceeds MAX_OUTST.
- afull_i is level-sensitive. Deassertion re-enables ready in the same cycle, and no internal state is kept for it.

## Timing
- Reset values: lkup_valid_o=0, skid_valid=0, outst_cnt_o=0, err_o=0. lkup_tag/index/offset/id_o=0.
- inct_arready_o follows from the reset state: it is 1 after reset unless some afull_i bit is high.
- Latency: a request accepted in cycle N appears on lkup_* with lkup_valid_o=1 in cycle N+1, provided the output register was free or draining in cycle N.
- Throughput: one request per cycle sustained while lkup_ready_i=1 and no gating condition is active.
- Backpressure:
  - With lkup_ready_i=0, at most two requests are held.
  - The second acceptance sets skid_valid, and inct_arready_o drops in the next cycle.
- Counter limit: the count reaching MAX_OUTST deasserts ready in the following cycle. A done_i at the limit re-enables ready one cycle after the pulse.
- Reset mid-operation: rst on any edge discards both buffered entries and clears the counter and err_o. Requests in flight downstream are not tracked afterward.

## Structure
- Shared package cc_pkg: ADDR_W/OFFSET_W/INDEX_W/TAG_W defaults, and the typedef of the decoded-request struct {tag, index, offset, id}. This package is shared with the tag-lookup and miss-handling blocks.
- One sub-module: cc_skid_buf, a generic two-entry valid/ready skid buffer parametrised on payload width.
- The decode and counter logic stay in the top module.

## Test plan
- Reset then single request: araddr=0x1234_5678, id=3, lkup_ready=1 → next cycle lkup_tag=0x02468, index=0x159, offset=0x38, id=3; outst_cnt=1.
- Backpressure: lkup_ready=0, stream addresses A0,A1,A2 → A0 and A1 accepted, arready low from cycle after A1. Then lkup_ready=1 → outputs A0, A1, A2 in order with no duplicate or loss.
- Outstanding limit (MAX_OUTST=8): 8 back-to-back requests with no done_i → arready=0, outst_cnt=8. One done_i → count 7, arready=1 the next cycle.
- Simultaneous hs_pulse and done_i at count 5 → count stays 5.
- Almost-full gating: assert afull_i[2] for 3 cycles while arvalid=1 → no acceptance in those cycles; acceptance resumes the same cycle afull_i[2] drops.
- Error/reset: done_i at count 0 → err_o=1, count 0. rst while holding 2 entries → lkup_valid_o=0, err_o=0, count 0 the next cycle.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: default address split and the
// decoded-request record exchanged between decode, tag-lookup and miss handling.
package cc_pkg;

    localparam int CC_ADDR_W   = 32;
    localparam int CC_OFFSET_W = 6;
    localparam int CC_INDEX_W  = 9;
    localparam int CC_TAG_W    = CC_ADDR_W - CC_INDEX_W - CC_OFFSET_W;
    localparam int CC_ID_W     = 4;

    // Decoded read request at the default geometry.
    typedef struct packed {
        logic [CC_TAG_W-1:0]    tag;
        logic [CC_INDEX_W-1:0]  index;
        logic [CC_OFFSET_W-1:0] offset;
        logic [CC_ID_W-1:0]     id;
    } cc_req_t;

endpackage

// File: rtl/cc_skid_buf.sv
// Generic two-entry valid/ready skid buffer. An output register feeds the
// consumer; a single skid register absorbs one extra beat when the consumer
// stalls. Entries leave strictly in arrival order.
module cc_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             in_fire;
    logic             drain;

    // Room for a new beat exists as long as the skid slot is free.
    assign in_ready_o  = !skid_valid_q;
    assign in_fire     = in_valid_i & in_ready_o;
    assign drain       = out_valid_q & out_ready_i;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    // Next-state: drain refills from skid first, then from a same-cycle input.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (drain) begin
            if (skid_valid_q) begin
                // Skid full implies no input could be accepted this cycle.
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_data_d = in_data_i;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data_i;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end
        end
    end

    // State registers; reset empties both slots and zeroes the payloads.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/cc_addr_decode_pipe.sv
// Read-address decoder: splits AXI read addresses into tag/index/offset,
// buffers them through a two-entry skid buffer towards tag lookup, and bounds
// in-flight reads with an outstanding counter. Acceptance is also gated by
// downstream almost-full flags.
module cc_addr_decode_pipe
    import cc_pkg::*;
#(
    parameter  int ADDR_W    = CC_ADDR_W,
    parameter  int OFFSET_W  = CC_OFFSET_W,
    parameter  int INDEX_W   = CC_INDEX_W,
    parameter  int ID_W      = CC_ID_W,
    parameter  int NUM_AFULL = 4,
    parameter  int MAX_OUTST = 8,
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W,
    localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    inct_araddr_i,
    input  logic [ID_W-1:0]      inct_arid_i,
    input  logic                 inct_arvalid_i,
    output logic                 inct_arready_o,
    input  logic [NUM_AFULL-1:0] afull_i,
    output logic                 lkup_valid_o,
    input  logic                 lkup_ready_i,
    output logic [TAG_W-1:0]     lkup_tag_o,
    output logic [INDEX_W-1:0]   lkup_index_o,
    output logic [OFFSET_W-1:0]  lkup_offset_o,
    output logic [ID_W-1:0]      lkup_id_o,
    input  logic                 done_i,
    output logic                 hs_pulse_o,
    output logic [CNT_W-1:0]     outst_cnt_o,
    output logic                 err_o
);

    // Decoded request at this instance's geometry.
    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
        logic [ID_W-1:0]     id;
    } req_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    req_t             in_req;
    req_t             out_req;
    logic             buf_ready;
    logic             hs;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Address split into cache coordinates.
    assign in_req.tag    = inct_araddr_i[ADDR_W-1 -: TAG_W];
    assign in_req.index  = inct_araddr_i[OFFSET_W +: INDEX_W];
    assign in_req.offset = inct_araddr_i[OFFSET_W-1:0];
    assign in_req.id     = inct_arid_i;

    // Ready never looks at arvalid, so AXI has no valid->ready loop.
    assign inct_arready_o = buf_ready & !(|afull_i) & (cnt_q < MAX_CNT);
    assign hs             = inct_arvalid_i & inct_arready_o;
    assign hs_pulse_o     = hs;

    cc_skid_buf #(
        .WIDTH ($bits(req_t))
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (hs),
        .in_ready_o  (buf_ready),
        .in_data_i   (in_req),
        .out_valid_o (lkup_valid_o),
        .out_ready_i (lkup_ready_i),
        .out_data_o  (out_req)
    );

    assign lkup_tag_o    = out_req.tag;
    assign lkup_index_o  = out_req.index;
    assign lkup_offset_o = out_req.offset;
    assign lkup_id_o     = out_req.id;

    // Outstanding count: accept adds, retire subtracts, a retire with nothing
    // outstanding is flagged instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (hs && done_i) begin
            cnt_d = cnt_q;
        end else if (hs) begin
            cnt_d = cnt_q + 1'b1;
        end else if (done_i) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign outst_cnt_o = cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_cc_addr_decode_pipe.sv
// Self-checking bench for cc_addr_decode_pipe: directed scenarios followed by
// random traffic, all checked against a queue-based request model.
module tb_cc_addr_decode_pipe;

    localparam int ADDR_W    = 32;
    localparam int OFFSET_W  = 6;
    localparam int INDEX_W   = 9;
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int ID_W      = 4;
    localparam int NUM_AFULL = 4;
    localparam int MAX_OUTST = 8;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [ADDR_W-1:0]    araddr = '0;
    logic [ID_W-1:0]      arid = '0;
    logic                 arvalid = 1'b0;
    logic                 arready;
    logic [NUM_AFULL-1:0] afull = '0;
    logic                 lvalid;
    logic                 lready = 1'b0;
    logic [TAG_W-1:0]     ltag;
    logic [INDEX_W-1:0]   lindex;
    logic [OFFSET_W-1:0]  loffset;
    logic [ID_W-1:0]      lid;
    logic                 done = 1'b0;
    logic                 hs;
    logic [CNT_W-1:0]     cnt;
    logic                 err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
    } mreq_t;

    mreq_t pend[$];
    int    m_cnt = 0;
    bit    m_err = 1'b0;

    always #5 clk = ~clk;

    cc_addr_decode_pipe #(
        .ADDR_W    (ADDR_W),
        .OFFSET_W  (OFFSET_W),
        .INDEX_W   (INDEX_W),
        .ID_W      (ID_W),
        .NUM_AFULL (NUM_AFULL),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inct_araddr_i  (araddr),
        .inct_arid_i    (arid),
        .inct_arvalid_i (arvalid),
        .inct_arready_o (arready),
        .afull_i        (afull),
        .lkup_valid_o   (lvalid),
        .lkup_ready_i   (lready),
        .lkup_tag_o     (ltag),
        .lkup_index_o   (lindex),
        .lkup_offset_o  (loffset),
        .lkup_id_o      (lid),
        .done_i         (done),
        .hs_pulse_o     (hs),
        .outst_cnt_o    (cnt),
        .err_o          (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare every output with the model, advance model.
    task automatic step(input bit v, input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                        input logic [NUM_AFULL-1:0] af, input bit lr, input bit dn);
        bit    exp_rdy;
        bit    exp_hs;
        mreq_t r;
        @(negedge clk);
        arvalid = v; araddr = a; arid = id; afull = af; lready = lr; done = dn;
        #1;
        exp_rdy = (pend.size() < 2) && (af == '0) && (m_cnt < MAX_OUTST);
        exp_hs  = v && exp_rdy;
        chk("arready", 64'(arready), 64'(exp_rdy));
        chk("hs_pulse", 64'(hs), 64'(exp_hs));
        chk("lkup_valid", 64'(lvalid), 64'(pend.size() > 0));
        chk("outst_cnt", 64'(cnt), 64'(m_cnt));
        chk("err", 64'(err), 64'(m_err));
        if (pend.size() > 0) begin
            r = pend[0];
            chk("lkup_tag", 64'(ltag), 64'(r.addr / (2 ** (INDEX_W + OFFSET_W))));
            chk("lkup_index", 64'(lindex), 64'((r.addr / (2 ** OFFSET_W)) % (2 ** INDEX_W)));
            chk("lkup_offset", 64'(loffset), 64'(r.addr % (2 ** OFFSET_W)));
            chk("lkup_id", 64'(lid), 64'(r.id));
        end
        $display("cyc v=%0b a=%08h id=%0h af=%0h lr=%0b dn=%0b | rdy=%0b hs=%0b lv=%0b cnt=%0d err=%0b",
                 v, a, id, af, lr, dn, arready, hs, lvalid, cnt, err);
        // Model advance for the coming edge.
        if (pend.size() > 0 && lr) void'(pend.pop_front());
        if (exp_hs) begin
            r.addr = a; r.id = id;
            pend.push_back(r);
        end
        if (exp_hs && dn) begin
            m_cnt = m_cnt;
        end else if (exp_hs) begin
            m_cnt++;
        end else if (dn) begin
            if (m_cnt == 0) m_err = 1'b1;
            else m_cnt--;
        end
    endtask

    task automatic idle(input bit lr);
        step(1'b0, '0, '0, '0, lr, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; arvalid = 1'b0; done = 1'b0; afull = '0;
        @(negedge clk);
        rst = 1'b0;
        pend.delete();
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    initial begin
        // Reset state.
        do_reset();
        idle(1'b1);
        chk("rst_tag", 64'(ltag), 64'h0);
        chk("rst_id", 64'(lid), 64'h0);
        chk("rst_ready", 64'(arready), 64'h1);

        // Single request and its decode.
        step(1'b1, 32'h1234_5678, 4'h3, '0, 1'b1, 1'b0);
        idle(1'b1);
        chk("single_tag", 64'(ltag), 64'h02468);
        chk("single_index", 64'(lindex), 64'h159);
        chk("single_offset", 64'(loffset), 64'h38);
        chk("single_id", 64'(lid), 64'h3);
        chk("single_cnt", 64'(cnt), 64'd1);

        // Backpressure: two held, third refused until the consumer drains.
        step(1'b1, 32'hA000_0040, 4'h0, '0, 1'b0, 1'b0);
        step(1'b1, 32'hA111_1081, 4'h1, '0, 1'b0, 1'b0);
        step(1'b1, 32'hA222_20C2, 4'h2, '0, 1'b0, 1'b0);
        chk("bp_ready_low", 64'(arready), 64'h0);
        step(1'b1, 32'hA222_20C2, 4'h2, '0, 1'b1, 1'b0);
        step(1'b1, 32'hA222_20C2, 4'h2, '0, 1'b1, 1'b0);
        chk("bp_a2_hs", 64'(hs), 64'h1);
        idle(1'b1);
        idle(1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        idle(1'b1);
        chk("bp_cnt_zero", 64'(cnt), 64'd0);

        // Outstanding limit.
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 64 + 32'h100), 4'(i), '0, 1'b1, 1'b0);
        idle(1'b1);
        chk("lim_ready", 64'(arready), 64'h0);
        chk("lim_cnt", 64'(cnt), 64'd8);
        step(1'b1, 32'hDEAD_0000, 4'h9, '0, 1'b1, 1'b1);
        idle(1'b1);
        chk("lim_cnt7", 64'(cnt), 64'd7);
        chk("lim_ready_back", 64'(arready), 64'h1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        step(1'b1, 32'hBEEF_0000, 4'h5, '0, 1'b1, 1'b1);
        idle(1'b1);
        chk("simul_cnt5", 64'(cnt), 64'd5);

        // Almost-full gating.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hC000_0000, 4'h6, 4'b0100, 1'b1, 1'b0);
            chk("afull_block", 64'(hs), 64'h0);
        end
        step(1'b1, 32'hC000_0000, 4'h6, '0, 1'b1, 1'b0);
        chk("afull_resume", 64'(hs), 64'h1);

        // Retire everything, then an erroneous retire.
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        idle(1'b1);
        chk("err_set", 64'(err), 64'h1);
        chk("err_cnt0", 64'(cnt), 64'd0);

        // Reset while holding two entries.
        step(1'b1, 32'h5555_0000, 4'h1, '0, 1'b0, 1'b0);
        step(1'b1, 32'h6666_0000, 4'h2, '0, 1'b0, 1'b0);
        do_reset();
        idle(1'b1);
        chk("rst2_valid", 64'(lvalid), 64'h0);
        chk("rst2_err", 64'(err), 64'h0);
        chk("rst2_cnt", 64'(cnt), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, 4'($urandom),
                 (($urandom % 8) == 0) ? 4'(1 << ($urandom % 4)) : 4'h0,
                 ($urandom % 3) != 0,
                 (m_cnt > 0) && (($urandom % 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
